// File: rtl/mux_sel_rr_arb.sv
// rtl/mux_sel_rr_arb.sv - round-robin arbiter driving a 4:1 mux sel with a valid/ready output stream
// Optional burst grants: define MUX_SEL_RR_ARB_BURST_EN.
module mux_sel_rr_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] gnt_nxt;
  logic       valid_nxt;
  logic       fire;
  logic       burst_keep;
  logic [1:0] ptr_rot;
  logic [2:0] pick_idle;
  logic [2:0] pick_fire;

  // Returns {found, index} of the first set bit scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign fire      = out_valid && out_ready;
  assign ptr_rot   = sel + 2'd1;
  assign pick_idle = rr_pick(req, ptr);
  assign pick_fire = rr_pick(req & ~gnt, ptr_rot);

`ifdef MUX_SEL_RR_ARB_BURST_EN
  logic [3:0] bcnt;
  logic [3:0] bcnt_nxt;

  assign burst_keep = req[sel] && ({1'b0, bcnt} + 5'd1 < 5'(MAX_BURST));

  always_comb begin
    bcnt_nxt = bcnt;
    if (state == IDLE) begin
      bcnt_nxt = 4'd0;
    end else if (fire) begin
      bcnt_nxt = burst_keep ? bcnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bcnt <= 4'd0;
    else        bcnt <= bcnt_nxt;
  end
`else
  assign burst_keep = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    valid_nxt = out_valid;
    unique case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idle[1:0];
          gnt_nxt   = 4'b0001 << pick_idle[1:0];
          valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        // Grant is frozen until fire; a burst hold keeps sel/gnt/ptr as-is.
        if (fire && !burst_keep) begin
          ptr_nxt = ptr_rot;
          if (pick_fire[2]) begin
            sel_nxt = pick_fire[1:0];
            gnt_nxt = 4'b0001 << pick_fire[1:0];
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arb.sv
// tb/tb_mux_sel_rr_arb.sv - self-checking bench for mux_sel_rr_arb with a behavioural reference model
module tb_mux_sel_rr_arb;

  localparam int MB = 4;
`ifdef MUX_SEL_RR_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  mux_sel_rr_arb #(.MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: integer pointer, current grant index, and beats taken in this grant.
  int m_ptr = 0;
  int m_sel = 0;
  bit m_valid = 0;
  int m_bcnt = 0;
  bit m_fire = 0;
  int m_fsrc = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    int k;
    m_fire = 0;
    if (!rst_n) begin
      m_ptr = 0; m_sel = 0; m_valid = 0; m_bcnt = 0;
    end else if (!m_valid) begin
      k = first_from(req, m_ptr);
      if (k >= 0) begin
        m_sel = k; m_valid = 1; m_bcnt = 0;
      end
    end else if (out_ready) begin
      m_fire = 1;
      m_fsrc = m_sel;
      if (BURST && req[m_sel] && (m_bcnt + 1 < MB)) begin
        m_bcnt++;
      end else begin
        m_bcnt = 0;
        m_ptr = (m_sel + 1) % 4;
        k = first_from(req & ~(4'b0001 << m_sel), m_ptr);
        if (k >= 0) m_sel = k;
        else m_valid = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid", int'(out_valid), int'(m_valid));
    chk("model_sel", int'(sel), m_sel);
    chk("model_gnt", int'(gnt), m_valid ? (1 << m_sel) : 0);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq[8];
    int n;
    rst_n = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);

    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_gnt", int'(gnt), 0);
      chk("idle_sel", int'(sel), 0);
    end

    // All requesting, always ready: 0,1,2,3,0 without bubbles
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    exp_seq = '{0, 1, 2, 3, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("all_sel", int'(sel), exp_seq[i]);
      chk("all_valid", int'(out_valid), 1);
    end

    // Stall on source 2, then one fire, then ptr=3 shows via next scan
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_gnt", int'(gnt), 4);
      chk("stall_sel", int'(sel), 2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_idle_valid", int'(out_valid), 0);
    chk("stall_idle_gnt", int'(gnt), 0);
    chk("stall_idle_sel", int'(sel), 2);
    req = 4'b1001;
    @(negedge clk);
    chk("ptr3_sel", int'(sel), 3);
    chk("ptr3_gnt", int'(gnt), 8);

    // Sources 0 and 3 back-to-back from ptr=0
    do_reset();
    req = 4'b1001; out_ready = 1'b1;
    exp_seq = '{0, 3, 0, 3, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_sel", int'(sel), exp_seq[i]);
    end

    // Sources 0 and 1 held: alternate, or bursts of MB when bursting
    do_reset();
    req = 4'b0011; out_ready = 1'b1;
    if (BURST) begin
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
      n = 8;
    end else begin
      exp_seq = '{0, 1, 0, 1, 0, 0, 0, 0};
      n = 4;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("burst_sel", int'(sel), exp_seq[i]);
    end

    // Reset during a grant
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_sel", int'(sel), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_sel", int'(sel), 0);
    rst_n = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    chk("post_rst_sel", int'(sel), 2);

    // Random traffic; a requester holds req until its beat is consumed
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] nreq;
      for (int i = 0; i < 4; i++) begin
        if (m_fire && m_fsrc == i)     nreq[i] = ($urandom_range(0, 1) == 1);
        else if (req[i])               nreq[i] = 1'b1;
        else                           nreq[i] = ($urandom_range(0, 9) < 3);
      end
      req = nreq;
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
